// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encoding and the
// symbol-time formula, so transmitter and receiver derive bit timing
// identically. Contains no logic of its own.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Cycles per line bit, truncated (434 for 50 MHz / 115200).
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Width of a counter running 0 .. n-1, never less than one bit.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; head entry readable combinationally.
// Latency: a pushed byte is visible at rdata_o on the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, wdata_i     write strobe and byte
//   pop_i               remove head entry
//   rdata_o             head entry (valid while !empty_o)
//   full_o, empty_o     occupancy flags
//   count_o             entries held, 0 .. Depth
module uart_byte_fifo #(
  parameter  int Depth = 4,
  localparam int AW    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [7:0]  mem_q [Depth];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok;
  logic        pop_ok;

  // Pointers differ only in the wrap bit when the buffer is full.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: ready/valid byte intake, FIFO, LSB-first serializer.
// Latency: byte accepted at edge t starts its start bit after edge t+1 (empty FIFO, idle line).
// Backpressure: DataInReady low while FIFO full or until the first edge after reset release.
//
// Ports:
//   Clock, Reset_n      clock, asynchronous active-low reset
//   DataIn, DataInValid byte offered by the UART store path
//   DataInReady         FIFO can take a byte this cycle
//   SOut                registered serial line, idle high
//   Busy                frame on the line or bytes still queued
//   Count               bytes queued, excluding the one being shifted
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int ClockFreq = 50_000_000,
  parameter  int BaudRate  = 115_200,
  parameter  int FifoDepth = 4,
  localparam int CountW    = $clog2(FifoDepth) + 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [7:0]        DataIn,
  input  logic              DataInValid,
  output logic              DataInReady,
  output logic              SOut,
  output logic              Busy,
  output logic [CountW-1:0] Count
);

  localparam int SymbolEdgeTime = symbol_edge_time(ClockFreq, BaudRate);
  localparam int SymW           = counter_width(SymbolEdgeTime);
  localparam logic [SymW-1:0] SymLast = SymW'(SymbolEdgeTime - 1);
  localparam logic [2:0]      BitLast = 3'(UART_DATA_BITS - 1);

  uart_state_e     state_q, state_d;
  logic [SymW-1:0] sym_cnt_q, sym_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sout_q, sout_d;
  logic            rdy_en_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CountW-1:0] fifo_count;
  logic              sym_expire;

  // Ready comes only from registered state; rdy_en_q keeps it low until the
  // first edge after reset release.
  assign DataInReady = rdy_en_q && !fifo_full;
  assign fifo_push   = DataInValid && DataInReady;
  assign sym_expire  = (sym_cnt_q == SymLast);

  uart_byte_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .push_i  (fifo_push),
    .wdata_i (DataIn),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        sym_cnt_d = '0;
        // Sees only registered occupancy, so a byte pushed this edge is
        // picked up on the next one.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_idx_d = '0;
          state_d   = START;
        end
      end

      START: begin
        if (sym_expire) begin
          sym_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          sym_cnt_d = sym_cnt_q + SymW'(1);
        end
      end

      DATA: begin
        if (sym_expire) begin
          sym_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == BitLast) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SymW'(1);
        end
      end

      STOP: begin
        if (sym_expire) begin
          sym_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SymW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        sym_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // The line level is computed from the next state so the flop output
  // changes on the same edge as the state register.
  always_comb begin
    sout_d = UART_STOP_BIT;
    case (state_d)
      START:   sout_d = UART_START_BIT;
      DATA:    sout_d = shift_d[0];
      default: sout_d = UART_STOP_BIT;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      sout_q    <= UART_STOP_BIT;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      sout_q    <= sout_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign SOut  = sout_q;
  assign Busy  = (state_q != IDLE) || (fifo_count != '0);
  assign Count = fifo_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: timing model of the serial line plus a line decoder scoreboard.
module tb_uart_tx_buffered;

  localparam int CF    = 1000;
  localparam int BR    = 100;
  localparam int DEPTH = 4;
  localparam int SYM   = CF / BR;
  localparam int FRAME = 10 * SYM;

  logic       Clock       = 1'b0;
  logic       Reset_n     = 1'b0;
  logic [7:0] DataIn      = 8'h00;
  logic       DataInValid = 1'b0;
  logic       DataInReady;
  logic       SOut;
  logic       Busy;
  logic [2:0] Count;

  always #5 Clock = ~Clock;

  uart_tx_buffered #(
    .ClockFreq (CF),
    .BaudRate  (BR),
    .FifoDepth (DEPTH)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .SOut        (SOut),
    .Busy        (Busy),
    .Count       (Count)
  );

  int errors = 0;
  int checks = 0;
  int prints = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (prints < 40) begin
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        prints++;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted byte becomes a frame whose pop edge is the later of
  // (accept edge + 1) and (previous pop edge + one frame length).
  typedef struct {
    int         acc;
    int         s;
    logic [7:0] d;
  } frm_t;

  frm_t       fq[$];
  logic [7:0] exp_q[$];
  int         cyc       = 0;
  bit         en        = 1'b0;
  bit         have_last = 1'b0;
  int         last_s    = 0;
  bit         m_accept  = 1'b0;
  int         s_new;
  int         peak      = 0;

  function automatic int m_count(input int e);
    int n = 0;
    foreach (fq[i]) if (fq[i].acc <= e && fq[i].s > e) n++;
    return n;
  endfunction

  function automatic bit m_inframe(input int e);
    foreach (fq[i]) if (fq[i].s <= e && e < fq[i].s + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_sout(input int e);
    int o;
    foreach (fq[i]) begin
      if (fq[i].s <= e && e < fq[i].s + FRAME) begin
        o = (e - fq[i].s) / SYM;
        if (o == 0) return 1'b0;
        if (o == 9) return 1'b1;
        return fq[i].d[o-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic bit m_idle(input int e);
    return (m_count(e) == 0) && !m_inframe(e);
  endfunction

  always @(posedge Clock) begin
    cyc++;
    m_accept = 1'b0;
    if (Reset_n) begin
      if (DataInValid && en && m_count(cyc - 1) < DEPTH) begin
        s_new = cyc + 1;
        if (have_last && last_s + FRAME > s_new) s_new = last_s + FRAME;
        fq.push_back('{cyc, s_new, DataIn});
        exp_q.push_back(DataIn);
        last_s    = s_new;
        have_last = 1'b1;
        m_accept  = 1'b1;
      end
      en = 1'b1;
      while (fq.size() > 0 && fq[0].s + FRAME < cyc - 2) void'(fq.pop_front());
    end
  end

  always @(negedge Reset_n) begin
    fq.delete();
    exp_q.delete();
    en        = 1'b0;
    have_last = 1'b0;
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge Clock) begin
    int ec;
    ec = m_count(cyc);
    check("sout",  SOut,        m_sout(cyc));
    check("count", Count,       ec);
    check("busy",  Busy,        (ec != 0) || m_inframe(cyc));
    check("ready", DataInReady, en && (ec < DEPTH));
    if (int'(Count) > peak) peak = Count;
  end

  // ---------------- line decoder / scoreboard ----------------
  int         mon_cnt = -1;
  logic [9:0] mon_bits;
  int         frames  = 0;

  always @(negedge Clock) begin
    logic [7:0] eb;
    if (!Reset_n) mon_cnt = -1;
    else if (mon_cnt < 0) begin
      if (SOut == 1'b0) mon_cnt = 0;
    end else mon_cnt++;
    if (mon_cnt >= 0 && (mon_cnt % SYM) == SYM / 2) begin
      mon_bits[mon_cnt / SYM] = SOut;
      if (mon_cnt / SYM == 9) begin
        frames++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          eb = exp_q.pop_front();
          check("frame_data", mon_bits[8:1], eb);
          check("frame_start_stop", {mon_bits[9], mon_bits[0]}, 2);
        end
        mon_cnt = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_byte(input logic [7:0] d);
    DataIn      = d;
    DataInValid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clock);
      #1;
      if (m_accept) return;
    end
    check("push_timeout", 1, 0);
  endtask

  task automatic release_valid();
    DataInValid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!m_idle(cyc) && guard < 6000) begin
      @(posedge Clock);
      #1;
      guard++;
    end
    check("idle_wait_timeout", guard >= 6000, 0);
  endtask

  task automatic wait_edge(input int target);
    int guard = 0;
    while (cyc < target && guard < 3000) begin
      @(posedge Clock);
      #1;
      guard++;
    end
    check("edge_wait_timeout", cyc, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int s;
    int bad;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_sout", SOut, 1);
    check("rst_busy", Busy, 0);
    check("rst_count", Count, 0);
    check("rst_ready", DataInReady, 0);
    Reset_n = 1'b1;
    #1;
    check("ready_before_edge", DataInReady, 0);
    @(posedge Clock);
    #1;
    check("ready_after_edge", DataInReady, 1);

    // single byte with explicit latency
    push_byte(8'hA5);
    release_valid();
    t = cyc;
    check("a5_line_high_at_accept", SOut, 1);
    @(posedge Clock);
    #1;
    check("a5_start_low", SOut, 0);
    wait_edge(t + 1 + FRAME - 1);
    check("a5_busy_last_stop_cycle", Busy, 1);
    @(posedge Clock);
    #1;
    check("a5_busy_dropped", Busy, 0);

    // back-to-back
    peak = 0;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    release_valid();
    wait_idle();
    check("b2b_peak", peak, 2);

    // full FIFO
    peak = 0;
    for (int d = 1; d <= 8; d++) push_byte(8'(d));
    release_valid();
    wait_idle();
    check("full_peak", peak, DEPTH);

    // push landing exactly on a STOP-expiry pop
    push_byte(8'h11);
    push_byte(8'h22);
    release_valid();
    wait_edge(last_s - 1);
    DataIn      = 8'h33;
    DataInValid = 1'b1;
    @(posedge Clock);
    #1;
    release_valid();
    check("simul_count", Count, 1);
    wait_idle();

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      push_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        release_valid();
        repeat ($urandom_range(1, 150)) @(posedge Clock);
        #1;
      end
    end
    release_valid();
    wait_idle();

    // reset during data bit 3 of 0x3C
    push_byte(8'h3C);
    release_valid();
    s = last_s;
    wait_edge(s + 4 * SYM + 3);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_sout", SOut, 1);
    check("midrst_count", Count, 0);
    check("midrst_busy", Busy, 0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    t = frames;
    push_byte(8'h81);
    release_valid();
    wait_idle();
    repeat (5) @(posedge Clock);
    check("post_rst_frames", frames - t, 1);

    // idle line
    bad = 0;
    repeat (500) begin
      @(negedge Clock);
      if (SOut !== 1'b1 || Busy !== 1'b0 || DataInReady !== 1'b1) bad++;
    end
    check("idle_line", bad, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
